// File: rtl/axi_config_pkg.sv
// Shared constants and width helpers for the config-port arbiter and its rd/wr adapters.
package axi_config_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int port_idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axi_config_arb_fifo.sv
// Read-ID FIFO: remembers which requester issued each in-flight read, oldest at head.
module axi_config_arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so push is legal at full when popping.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_config_arb.sv
// Round-robin arbiter sharing one register port between PORTS requesters; read
// responses are routed back to their issuer through an in-order ID FIFO.
module axi_config_arb
  import axi_config_pkg::*;
#(
  parameter int PORTS           = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            s_req_valid,
  output logic [PORTS-1:0]            s_req_ready,
  input  logic [PORTS-1:0]            s_req_we,
  input  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0] s_req_wdata,
  input  logic [PORTS*STRB_WIDTH-1:0] s_req_wstrb,
  output logic [PORTS-1:0]            s_resp_valid,
  output logic [DATA_WIDTH-1:0]       s_resp_rdata,
  output logic                        rd,
  output logic                        wr,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [STRB_WIDTH-1:0]       wstrb,
  input  logic [DATA_WIDTH-1:0]       rdata,
  input  logic                        rvalid,
  output logic                        err_unexpected
);

  localparam int PIW = port_idx_width(PORTS);

  logic [PIW-1:0]        r_rr_ptr;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_err;

  logic [PIW-1:0]        w_cand;
  logic                  w_found;
  logic                  w_cand_we;
  logic                  w_full;
  logic                  w_empty;
  logic [PIW-1:0]        w_head;
  logic                  w_blocked;
  logic                  w_accept;
  logic                  w_read_acc;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [PIW-1:0]        w_resp_idx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_WIDTH-1:0] w_sel_wstrb;

  // r_rr_ptr is the port with highest priority this cycle (last grant + 1).
  always_comb begin : rr_search
    int sum;
    w_cand  = '0;
    w_found = 1'b0;
    sum     = 0;
    for (int k = 0; k < PORTS; k++) begin
      sum = int'(r_rr_ptr) + k;
      if (sum >= PORTS) sum = sum - PORTS;
      if (!w_found && s_req_valid[PIW'(sum)]) begin
        w_found = 1'b1;
        w_cand  = PIW'(sum);
      end
    end
  end

  always_comb begin : payload_sel
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_cand == PIW'(i)) begin
        w_sel_addr  = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = s_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wstrb = s_req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // A blocked read candidate stalls everyone rather than being skipped, keeping order fair.
  assign w_cand_we  = s_req_we[w_cand];
  assign w_blocked  = w_full && !rvalid;
  assign w_accept   = !rst && w_found && !((w_cand_we == OP_READ) && w_blocked);
  assign w_read_acc = w_accept && (w_cand_we == OP_READ);
  assign w_bypass   = w_read_acc && rvalid && w_empty;
  assign w_push     = w_read_acc && !w_bypass;
  assign w_pop      = !rst && rvalid && !w_empty;
  assign w_resp_idx = w_empty ? w_cand : w_head;

  axi_config_arb_fifo #(
    .WIDTH (PIW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_cand),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_comb begin : handshake
    s_req_ready  = '0;
    s_resp_valid = '0;
    if (w_accept) s_req_ready[w_cand] = 1'b1;
    if (w_pop || w_bypass) s_resp_valid[w_resp_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rd <= w_read_acc;
      r_wr <= w_accept && (w_cand_we == OP_WRITE);
      if (w_accept) begin
        r_addr   <= w_sel_addr;
        r_rr_ptr <= (w_cand == PIW'(PORTS - 1)) ? '0 : w_cand + 1'b1;
        if (w_cand_we == OP_WRITE) begin
          r_wdata <= w_sel_wdata;
          r_wstrb <= w_sel_wstrb;
        end
      end
      if (rvalid && w_empty && !w_bypass) r_err <= 1'b1;
    end
  end

  // Strobes are masked while rst is high so a pulse registered just before reset never escapes.
  assign rd             = r_rd && !rst;
  assign wr             = r_wr && !rst;
  assign addr           = r_addr;
  assign wdata          = r_wdata;
  assign wstrb          = r_wstrb;
  assign s_resp_rdata   = rdata;
  assign err_unexpected = r_err;

endmodule
